// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: deglitched PS/2 frame receiver producing scan bytes and a {prev,cur} keycode history
module ps2_scan_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  scan_byte,
  output logic        byte_valid,
  output logic [15:0] keycode,
  output logic        frame_err,
  output logic        busy
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_fclk, r_fclk_q;
  logic [FW-1:0]          r_fcnt;
  state_t                 r_state;
  logic [2:0]             r_bcnt;
  logic [7:0]             r_shreg;
  logic                   r_par;
  logic [TW-1:0]          r_tcnt;
  logic                   w_clk_s, w_dat_s, w_e, w_tmo;
  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_e     = r_fclk_q & ~r_fclk;
  assign w_tmo   = r_tcnt == TW'(TIMEOUT_CYC - 1);
  assign busy    = r_state != IDLE;
  // synchronise both pins and only let the clock level change after FILTER_LEN steady samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_fclk     <= 1'b1;
      r_fclk_q   <= 1'b1;
      r_fcnt     <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_fclk_q   <= r_fclk;
      if (w_clk_s == r_fclk) r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fclk <= w_clk_s;
        r_fcnt <= '0;
      end else r_fcnt <= r_fcnt + 1'b1;
    end
  end
  // frame FSM stepped by filtered falling edges, with a watchdog that drops stalled frames
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bcnt     <= '0;
      r_shreg    <= '0;
      r_par      <= 1'b0;
      r_tcnt     <= '0;
      scan_byte  <= '0;
      keycode    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      r_tcnt     <= (w_e || r_state == IDLE) ? '0 : r_tcnt + 1'b1;
      if (w_e) begin
        case (r_state)
          IDLE: if (!w_dat_s) begin
            r_state <= DATA;
            r_bcnt  <= '0;
          end
          DATA: begin
            r_shreg <= {w_dat_s, r_shreg[7:1]};
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_dat_s;
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (w_dat_s && (^r_shreg ^ r_par)) begin
              byte_valid <= 1'b1;
              scan_byte  <= r_shreg;
              keycode    <= {keycode[7:0], r_shreg};
            end else frame_err <= 1'b1;
          end
        endcase
      end else if (r_state != IDLE && w_tmo) begin
        r_state   <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed and random PS/2 frames checked against a queue-of-good-bytes model
module tb_ps2_scan_rx;
  localparam int SYNC = 2, FILT = 8, TO = 400, H = 40;
  logic        clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0]  scan_byte;
  logic        byte_valid, frame_err, busy;
  logic [15:0] keycode;
  int checks = 0, failures = 0, cyc = 0, bv_cnt = 0, fe_cnt = 0, fe_cyc = 0, fall_cyc = 0;
  logic bv_q = 1'b0, fe_q = 1'b0;
  logic [7:0] good_q[$];
  always #5 clk = ~clk;
  ps2_scan_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .scan_byte(scan_byte),
    .byte_valid(byte_valid), .keycode(keycode), .frame_err(frame_err), .busy(busy));
  always @(posedge clk) cyc <= cyc + 1;
  // pulse monitor: pulses are single-cycle and mutually exclusive
  always @(negedge clk) begin
    if (byte_valid || frame_err) begin
      checks++;
      assert (!(byte_valid && frame_err) && !(byte_valid && bv_q) && !(frame_err && fe_q))
        else begin
          failures++;
          $error("FAIL pulse_shape bv=%0b fe=%0b bv_prev=%0b fe_prev=%0b required single exclusive pulses",
                 byte_valid, frame_err, bv_q, fe_q);
        end
    end
    bv_cnt += int'(byte_valid);
    fe_cnt += int'(frame_err);
    if (frame_err) fe_cyc = cyc;
    bv_q = byte_valid;
    fe_q = frame_err;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(H / 2);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(14);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(H / 2 - 17);
    end else wait_cyc(H / 2);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits, input int gbit);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == gbit);
    ps2_data = 1'b1;
  endtask
  function automatic logic [15:0] exp_key();
    int n;
    n = good_q.size();
    return {n >= 2 ? good_q[n-2] : 8'h00, n >= 1 ? good_q[n-1] : 8'h00};
  endfunction
  task automatic xfer(input logic [7:0] d, input logic par, input logic stop, input int gbit);
    int b0, f0;
    logic good;
    b0 = bv_cnt;
    f0 = fe_cnt;
    good = stop && ((^d) != par);
    send_frame(d, par, stop, 11, gbit);
    if (good) good_q.push_back(d);
    chk("bv_count", bv_cnt - b0, int'(good));
    chk("fe_count", fe_cnt - f0, int'(!good));
    chk("keycode", int'(keycode), int'(exp_key()));
    chk("scan_byte", int'(scan_byte), int'(exp_key() & 16'h00FF));
    chk("busy_after", int'(busy), 0);
  endtask
  initial begin
    int b0, f0;
    logic [7:0] d;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    chk("rst_scan", int'(scan_byte), 0);
    chk("rst_key", int'(keycode), 0);
    chk("rst_bv", int'(byte_valid), 0);
    chk("rst_fe", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    xfer(8'h1C, ~^8'h1C, 1'b1, -1);
    xfer(8'hF0, ~^8'hF0, 1'b1, -1);
    xfer(8'h1C, ~^8'h1C, 1'b1, -1);
    xfer(8'h1C, ^8'h1C, 1'b1, -1);
    xfer(8'h1B, ~^8'h1B, 1'b1, -1);
    b0 = bv_cnt;
    f0 = fe_cnt;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    chk("idle_glitch_busy", int'(busy), 0);
    chk("idle_glitch_pulses", bv_cnt + fe_cnt - b0 - f0, 0);
    xfer(8'h23, ~^8'h23, 1'b1, 4);
    f0 = fe_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
    wait_cyc(20);
    chk("partial_busy", int'(busy), 1);
    for (int i = 0; i < TO + 100 && fe_cnt == f0; i++) wait_cyc(1);
    chk("timeout_fe", fe_cnt - f0, 1);
    chk("timeout_delay", fe_cyc - fall_cyc, TO + SYNC + FILT + 1);
    chk("timeout_busy", int'(busy), 0);
    xfer(8'h75, ~^8'h75, 1'b1, -1);
    send_frame(8'h6B, ~^8'h6B, 1'b1, 7, -1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    good_q.delete();
    b0 = bv_cnt;
    f0 = fe_cnt;
    wait_cyc(2);
    chk("midrst_scan", int'(scan_byte), 0);
    chk("midrst_key", int'(keycode), 0);
    chk("midrst_busy", int'(busy), 0);
    wait_cyc(TO + 100);
    chk("midrst_pulses", bv_cnt + fe_cnt - b0 - f0, 0);
    xfer(8'h6B, ~^8'h6B, 1'b1, -1);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      xfer(d, (~^d) ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 7) != 0, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
